// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and defaults for the fetch sequencer.
package pc_fetch_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int unsigned RESET_VEC_DEF = 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: redirect decode, redirect target and sequential next-PC adders.
module pc_next_calc
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_i,
  input  logic              aluzero_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic [ADDR_W-1:0] branch_off_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] target_o,
  output logic [ADDR_W-1:0] pc_seq_o
);
  assign redirect_o = jump_i | (branch_i & aluzero_i);
  assign target_o   = jump_i ? jump_target_i : branch_pc_i + ADDR_W'(1) + branch_off_i;
  assign pc_seq_o   = pc_i + ADDR_W'(1);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC owner and req/ack fetch sequencer with redirect squash.
// Define PC_FETCH_PERF_EN to add the fetch/squash/stall performance counters.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_i,
  input  logic              aluzero_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic [ADDR_W-1:0] branch_off_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] pc_o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_squash_o,
  output logic [31:0]       perf_stall_o
`endif
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d, target, pc_seq;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d, squash_q, squash_d;
  logic              redirect, issue, drop, deliver;
  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc_i          (pc_q),
    .branch_i      (branch_i),
    .aluzero_i     (aluzero_i),
    .branch_pc_i   (branch_pc_i),
    .branch_off_i  (branch_off_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .redirect_o    (redirect),
    .target_o      (target),
    .pc_seq_o      (pc_seq)
  );
  assign issue   = state_q == REQ && !stall_i && !redirect;
  assign drop    = squash_q | redirect;
  assign deliver = state_q == WAIT && imem_ack_i && !drop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = issue ? WAIT : REQ;
      WAIT:    state_d = imem_ack_i ? (drop ? REQ : HOLD) : WAIT;
      HOLD:    state_d = (redirect | instr_ready_i) ? REQ : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // The outstanding request keeps its own address so a redirect can move pc_q under it.
  always_comb begin
    pc_d     = (state_q != IDLE && redirect) ? target :
               (state_q == WAIT && imem_ack_i && !squash_q) ? pc_seq : pc_q;
    addr_d   = issue ? pc_q : addr_q;
    squash_d = state_q == WAIT && !imem_ack_i && drop;
    valid_d  = deliver | (state_q == HOLD && valid_q && !redirect && !instr_ready_i);
    instr_d  = deliver ? imem_data_i : instr_q;
    ipc_d    = deliver ? addr_q : ipc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q     <= RESET_VEC;
      addr_q   <= RESET_VEC;
      ipc_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ipc_q    <= ipc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
    end
  always_comb begin
    imem_req_o    = state_q == WAIT;
    imem_addr_o   = addr_q;
    instr_o       = instr_q;
    instr_pc_o    = ipc_q;
    instr_valid_o = valid_q;
    pc_o          = pc_q;
  end
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_squash_q, perf_stall_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_squash_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_q + {31'd0, state_q == HOLD && instr_ready_i && !redirect};
      perf_squash_q <= perf_squash_q + {31'd0, state_q == WAIT && imem_ack_i && drop};
      perf_stall_q  <= perf_stall_q + {31'd0, state_q == REQ && stall_i};
    end
  assign perf_fetch_o  = perf_fetch_q;
  assign perf_squash_o = perf_squash_q;
  assign perf_stall_o  = perf_stall_q;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic against a next-PC reference model.
module tb_pc_fetch_ctrl;
  logic        clk, rst_n, stall_i, imem_req_o, imem_ack_i, instr_valid_o, instr_ready_i;
  logic        branch_i, aluzero_i, jump_i;
  logic [31:0] imem_addr_o, imem_data_i, instr_o, instr_pc_o, branch_pc_i, branch_off_i;
  logic [31:0] jump_target_i, pc_o;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch_o, perf_squash_o, perf_stall_o;
`endif
  int          total, passed, fails, deliveries, lat;
  logic [31:0] model_pc, prev_addr;
  logic        prev_req, redir;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .branch_i      (branch_i),
    .aluzero_i     (aluzero_i),
    .branch_pc_i   (branch_pc_i),
    .branch_off_i  (branch_off_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .pc_o          (pc_o)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_squash_o (perf_squash_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req_o; i++) tick();
    chk("req_timeout", {63'd0, imem_req_o}, 64'd1);
  endtask

  task automatic ack_with(input logic [31:0] d);
    imem_ack_i = 1'b1;
    imem_data_i = d;
    tick();
    imem_ack_i = 1'b0;
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; fails = 0; deliveries = 0; lat = 0;
    rst_n = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0; instr_ready_i = 1'b0;
    branch_i = 1'b0; aluzero_i = 1'b0; branch_pc_i = '0; branch_off_i = '0;
    jump_i = 1'b0; jump_target_i = '0;
    tick(); tick();
    chk("rst_pc", pc_o, 0);
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_instr_pc", instr_pc_o, 0);
    rst_n = 1'b1;
    wait_req();
    chk("first_addr", imem_addr_o, 0);
    ack_with(32'hA);
    chk("a_valid", instr_valid_o, 1);
    chk("a_instr", instr_o, 32'hA);
    chk("a_pc", instr_pc_o, 0);
    accept();
    chk("a_drop_valid", instr_valid_o, 0);
    wait_req();
    chk("b_addr", imem_addr_o, 1);
    ack_with(32'hB);
    chk("b_instr", instr_o, 32'hB);
    chk("b_pc", instr_pc_o, 1);
    chk("b_pc_o", pc_o, 2);
    accept();
    // branch taken while the fetch of PC 2 is still outstanding
    wait_req();
    chk("c_addr", imem_addr_o, 2);
    branch_i = 1'b1; aluzero_i = 1'b1; branch_pc_i = 4; branch_off_i = 3;
    tick();
    branch_i = 1'b0; aluzero_i = 1'b0;
    chk("sq_pc_o", pc_o, 8);
    chk("sq_req_held", imem_req_o, 1);
    chk("sq_addr_held", imem_addr_o, 2);
    tick();
    ack_with(32'hDEAD);
    chk("sq_dropped", instr_valid_o, 0);
    wait_req();
    chk("sq_next_addr", imem_addr_o, 8);
    // jump and taken branch together, in the ack cycle itself
    jump_i = 1'b1; jump_target_i = 32'h40; branch_i = 1'b1; aluzero_i = 1'b1;
    ack_with(32'h5555);
    jump_i = 1'b0; branch_i = 1'b0; aluzero_i = 1'b0;
    chk("jmp_dropped", instr_valid_o, 0);
    wait_req();
    chk("jmp_addr", imem_addr_o, 32'h40);
    ack_with(32'h1234);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", instr_valid_o, 1);
      chk("bp_instr", instr_o, 32'h1234);
      chk("bp_pc", instr_pc_o, 32'h40);
      chk("bp_no_req", imem_req_o, 0);
      tick();
    end
    accept();
    chk("bp_pc_o", pc_o, 32'h41);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_req", imem_req_o, 0);
    end
`ifdef PC_FETCH_PERF_EN
    chk("perf_stall", perf_stall_o, 3);
    chk("perf_fetch", perf_fetch_o, 3);
    chk("perf_squash", perf_squash_o, 2);
`endif
    stall_i = 1'b0;
    wait_req();
    chk("post_stall_addr", imem_addr_o, 32'h41);
    #2 rst_n = 1'b0;
    #1 chk("arst_req", imem_req_o, 0);
    imem_ack_i = 1'b1; imem_data_i = 32'hBAD;
    tick(); tick();
    chk("arst_pc", pc_o, 0);
    chk("arst_valid", instr_valid_o, 0);
    chk("arst_req2", imem_req_o, 0);
`ifdef PC_FETCH_PERF_EN
    chk("arst_perf", perf_stall_o, 0);
`endif
    imem_ack_i = 1'b0;
    rst_n = 1'b1;
    wait_req();
    chk("restart_addr", imem_addr_o, 0);
    ack_with(32'h77);
    chk("restart_instr", instr_o, 32'h77);
    chk("restart_pc", instr_pc_o, 0);
    accept();
    // randomized traffic: model holds only the next PC that must be fetched/delivered
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_pc = 0; prev_req = 1'b0; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (imem_req_o && !prev_req) begin
        chk("rnd_addr", imem_addr_o, model_pc);
        lat = $urandom_range(0, 3);
      end else if (imem_req_o) chk("rnd_addr_stable", imem_addr_o, prev_addr);
      if (!imem_req_o && !instr_valid_o) chk("rnd_pc_o", pc_o, model_pc);
      prev_req = imem_req_o;
      prev_addr = imem_addr_o;
      stall_i = $urandom_range(0, 3) == 0;
      instr_ready_i = $urandom_range(0, 2) != 0;
      imem_ack_i = imem_req_o && lat == 0;
      imem_data_i = imem_ack_i ? mem(imem_addr_o) : $urandom;
      if (imem_req_o && lat != 0) lat--;
      branch_pc_i = $urandom; branch_off_i = $urandom; jump_target_i = $urandom;
      if (c > 3 && $urandom_range(0, 7) == 0) begin
        jump_i = $urandom_range(0, 1) == 1;
        branch_i = 1'b1;
        aluzero_i = !jump_i || $urandom_range(0, 1) == 1;
      end else begin
        jump_i = 1'b0;
        branch_i = $urandom_range(0, 1) == 1;
        aluzero_i = 1'b0;
      end
      redir = jump_i | (branch_i & aluzero_i);
      if (instr_valid_o && instr_ready_i && !redir) begin
        chk("rnd_instr_pc", instr_pc_o, model_pc);
        chk("rnd_instr", instr_o, mem(model_pc));
        model_pc = model_pc + 1;
        deliveries++;
      end
      if (redir) model_pc = jump_i ? jump_target_i : branch_pc_i + 32'd1 + branch_off_i;
      tick();
    end
    chk("rnd_progress", {63'd0, deliveries > 50}, 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
